// File: rtl/fetch_queue.sv
// Instruction fetch stage: addresses the ROM every cycle, buffers {pc, instr} pairs
// in a small prefetch FIFO and hands the head entry to decode over valid/ready.
module fetch_queue #(
  parameter int unsigned A_BITS   = 10,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [A_BITS-1:0]          rom_pc,
  input  logic [15:0]                rom_instr,
  input  logic                       halt,
  input  logic                       redirect_valid,
  input  logic [A_BITS-1:0]          redirect_pc,
  output logic                       out_valid,
  output logic [15:0]                out_instr,
  output logic [A_BITS-1:0]          out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [A_BITS-1:0] START_PC = A_BITS'(RESET_PC);

  logic [A_BITS-1:0] fetch_pc;
  logic [A_BITS-1:0] pc_mem    [DEPTH];
  logic [15:0]       instr_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full;
  logic              pop;
  logic              push;

  assign rom_pc    = fetch_pc;
  assign count     = count_q;
  assign full      = (count_q == FULL_CNT);
  // Head is hidden during a redirect so decode never consumes a wrong-path entry.
  assign out_valid = (count_q != '0) && !redirect_valid;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A full queue still accepts a new entry when the head leaves in the same cycle.
  assign push      = !redirect_valid && !halt && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= START_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 1'b1;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage carries data only; its contents are don't-care until count says otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= rom_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table for the listed corner cases, then
// random traffic checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int A_BITS = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [A_BITS-1:0] rom_pc;
  logic [15:0]       rom_instr;
  logic              halt;
  logic              redirect_valid;
  logic [A_BITS-1:0] redirect_pc;
  logic              out_valid;
  logic [15:0]       out_instr;
  logic [A_BITS-1:0] out_pc;
  logic              out_ready;
  logic [2:0]        count;

  fetch_queue #(.A_BITS(A_BITS), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .rom_pc(rom_pc), .rom_instr(rom_instr), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;
  assign rom_instr = 16'hA000 | {6'b0, rom_pc};

  typedef struct {
    logic rst, redir;
    logic [9:0] rpc;
    logic halt, ready, chk, e_valid;
    logic [2:0] e_count;
    logic [9:0] e_rom, e_pc;
  } vec_t;

  typedef struct { logic [9:0] pc; logic [15:0] instr; } entry_t;

  vec_t   vecs[$];
  entry_t mq[$];
  logic [9:0] m_pc = '0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t v(input logic r, input logic rd, input logic [9:0] rp,
                             input logic h, input logic rdy, input logic c,
                             input logic ev, input logic [2:0] ec,
                             input logic [9:0] erom, input logic [9:0] epc);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rp; t.halt = h; t.ready = rdy; t.chk = c;
    t.e_valid = ev; t.e_count = ec; t.e_rom = erom; t.e_pc = epc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: queue semantics straight from the fetch rules.
  task automatic model_step(input logic r, input logic rd, input logic [9:0] rp,
                            input logic h, input logic rdy);
    logic did_pop;
    entry_t e;
    if (r) begin
      mq.delete(); m_pc = '0;
    end else if (rd) begin
      mq.delete(); m_pc = rp;
    end else begin
      did_pop = (mq.size() != 0) && rdy;
      if (did_pop) void'(mq.pop_front());
      if (!h && (mq.size() < DEPTH)) begin
        e.pc = m_pc; e.instr = 16'hA000 | {6'b0, m_pc};
        mq.push_back(e);
        m_pc = m_pc + 10'd1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [9:0] rp,
                       input logic h, input logic rdy);
    rst = r; redirect_valid = rd; redirect_pc = rp; halt = h; out_ready = rdy;
  endtask

  task automatic finish_cycle(input logic r, input logic rd, input logic [9:0] rp,
                              input logic h, input logic rdy);
    @(posedge clk);
    model_step(r, rd, rp, h, rdy);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // reset, then streaming with out_ready=1
    vecs.push_back(v(1,0,0,0,1, 0, 0,0,0,0));
    vecs.push_back(v(1,0,0,0,1, 0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,1, 1, 0,0,10'h000,0));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h001,10'h000));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h002,10'h001));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h003,10'h002));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h004,10'h003));
    // backpressure: fill to DEPTH and hold
    vecs.push_back(v(1,0,0,0,0, 0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 1, 0,0,10'h000,0));
    vecs.push_back(v(0,0,0,0,0, 1, 1,1,10'h001,10'h000));
    vecs.push_back(v(0,0,0,0,0, 1, 1,2,10'h002,10'h000));
    vecs.push_back(v(0,0,0,0,0, 1, 1,3,10'h003,10'h000));
    vecs.push_back(v(0,0,0,0,0, 1, 1,4,10'h004,10'h000));
    vecs.push_back(v(0,0,0,0,0, 1, 1,4,10'h004,10'h000));
    vecs.push_back(v(0,0,0,0,0, 1, 1,4,10'h004,10'h000));
    vecs.push_back(v(0,0,0,0,0, 1, 1,4,10'h004,10'h000));
    // release: full + pop keeps count at DEPTH, head and fetch advance together
    vecs.push_back(v(0,0,0,0,1, 1, 1,4,10'h004,10'h000));
    vecs.push_back(v(0,0,0,0,1, 1, 1,4,10'h005,10'h001));
    vecs.push_back(v(0,0,0,0,1, 1, 1,4,10'h006,10'h002));
    vecs.push_back(v(0,0,0,0,1, 1, 1,4,10'h007,10'h003));
    vecs.push_back(v(0,0,0,0,1, 1, 1,4,10'h008,10'h004));
    vecs.push_back(v(0,0,0,0,1, 1, 1,4,10'h009,10'h005));
    // drain one under halt, then redirect with count=3
    vecs.push_back(v(0,0,0,1,1, 1, 1,4,10'h00A,10'h006));
    vecs.push_back(v(0,1,10'h100,0,1, 1, 0,3,10'h00A,0));
    vecs.push_back(v(0,0,0,0,1, 1, 0,0,10'h100,0));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h101,10'h100));
    // wrap at top of address space, then halt drains and freezes fetch
    vecs.push_back(v(0,1,10'h3FE,0,1, 1, 0,1,10'h102,0));
    vecs.push_back(v(0,0,0,0,1, 1, 0,0,10'h3FE,0));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h3FF,10'h3FE));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h000,10'h3FF));
    vecs.push_back(v(0,0,0,1,1, 1, 1,1,10'h001,10'h000));
    vecs.push_back(v(0,0,0,1,1, 1, 0,0,10'h001,0));
    vecs.push_back(v(0,0,0,1,1, 1, 0,0,10'h001,0));
    vecs.push_back(v(0,0,0,0,1, 1, 0,0,10'h001,0));
    vecs.push_back(v(0,0,0,0,1, 1, 1,1,10'h002,10'h001));
    // refill to DEPTH, then reset and redirect together: reset wins
    vecs.push_back(v(0,0,0,0,0, 1, 1,1,10'h003,10'h002));
    vecs.push_back(v(0,0,0,0,0, 1, 1,2,10'h004,10'h002));
    vecs.push_back(v(0,0,0,0,0, 1, 1,3,10'h005,10'h002));
    vecs.push_back(v(1,1,10'h200,0,0, 1, 0,4,10'h006,0));
    vecs.push_back(v(0,0,0,0,0, 1, 0,0,10'h000,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].halt, vecs[i].ready);
      #4;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
        check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
        check($sformatf("vec%0d rom_pc", i), 32'(rom_pc), 32'(vecs[i].e_rom));
        if (vecs[i].e_valid) begin
          check($sformatf("vec%0d out_pc", i), 32'(out_pc), 32'(vecs[i].e_pc));
          check($sformatf("vec%0d out_instr", i), 32'(out_instr),
                32'(16'hA000 | {6'b0, vecs[i].e_pc}));
        end
      end
      finish_cycle(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].halt, vecs[i].ready);
    end

    for (int i = 0; i < 3000; i++) begin
      logic r, rd, h, rdy, ev;
      logic [9:0] rp;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rp  = 10'($urandom);
      h   = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, rd, rp, h, rdy);
      #4;
      ev = (mq.size() != 0) && !rd;
      check("rnd out_valid", 32'(out_valid), 32'(ev));
      check("rnd count", 32'(count), 32'(mq.size()));
      check("rnd rom_pc", 32'(rom_pc), 32'(m_pc));
      if (ev) begin
        check("rnd out_pc", 32'(out_pc), 32'(mq[0].pc));
        check("rnd out_instr", 32'(out_instr), 32'(mq[0].instr));
      end
      finish_cycle(r, rd, rp, h, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
